// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Receive-side PRBS checker for the emulated channel. It runs in the clk_sys
// domain after the RX filter. On every sample strobe it slices the filtered
// sample to one bit. It then lines up a local LFSR with the received stream,
// declares lock, and counts the bits compared and the bit errors seen while
// locked. Use one instance per sampling edge (cke_rx_p or cke_rx_n).
//
// Ports
//   clk        in   1            system clock (clk_sys)
//   rst_n      in   1            synchronous reset, active low
//   cke        in   1            sample strobe; all state advances only when 1
//   sig        in   SIG_WIDTH    signed two's-complement filtered RX sample
//   clr_cnt    in   1            synchronous clear of bit_count/err_count
//   rx_bit     out  1            registered sliced bit
//   locked     out  1            1 while in the LOCKED state
//   err_pulse  out  1            one-cycle pulse per mismatched bit while LOCKED
//   bit_count  out  COUNT_WIDTH  bits compared while LOCKED (saturating)
//   err_count  out  COUNT_WIDTH  errors while LOCKED (saturating)
// -----------------------------------------------------------------------------
module prbs_checker #(
  parameter int SIG_WIDTH   = 16,
  parameter int LFSR_WIDTH  = 7,
  parameter int TAP_A       = 7,
  parameter int TAP_B       = 6,
  parameter int LOCK_COUNT  = 64,
  parameter int LOSS_WINDOW = 128,
  parameter int LOSS_THRESH = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cke,
  input  logic signed [SIG_WIDTH-1:0] sig,
  input  logic                        clr_cnt,
  output logic                        rx_bit,
  output logic                        locked,
  output logic                        err_pulse,
  output logic [COUNT_WIDTH-1:0]      bit_count,
  output logic [COUNT_WIDTH-1:0]      err_count
);

  localparam int SEED_W = $clog2(LFSR_WIDTH + 1);
  localparam int OK_W   = $clog2(LOCK_COUNT + 1);
  localparam int WB_W   = $clog2(LOSS_WINDOW + 1);
  localparam int WE_W   = $clog2(LOSS_THRESH + 1);

  localparam logic signed [SIG_WIDTH-1:0] SIG_ZERO = '0;
  localparam logic [COUNT_WIDTH-1:0]      CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t                 state, state_nxt;
  logic [LFSR_WIDTH-1:0]  lfsr, lfsr_nxt;
  logic [SEED_W-1:0]      seed_cnt, seed_cnt_nxt;
  logic [OK_W-1:0]        ok_cnt, ok_cnt_nxt;
  logic [WB_W-1:0]        win_bits, win_bits_nxt;
  logic [WE_W-1:0]        win_errs, win_errs_nxt;
  logic [COUNT_WIDTH-1:0] bit_count_nxt, err_count_nxt;
  logic                   rx_bit_nxt, err_pulse_nxt, locked_nxt;

  logic                   slice_bit, pred_bit, mismatch;
  logic [LFSR_WIDTH-1:0]  seed_shift, pred_shift;
  logic [WE_W-1:0]        win_errs_inc;

  // A signed ">= 0" test is the same as inverting the sign bit. Writing it as
  // a compare keeps every input bit in use.
  assign slice_bit    = (sig >= SIG_ZERO);
  assign pred_bit     = lfsr[TAP_A-1] ^ lfsr[TAP_B-1];
  assign mismatch     = slice_bit ^ pred_bit;
  assign seed_shift   = {lfsr[LFSR_WIDTH-2:0], slice_bit};
  // Once the seed is loaded, the LFSR shifts in its own prediction. A channel
  // error therefore never enters the register and cannot cause follow-on errors.
  assign pred_shift   = {lfsr[LFSR_WIDTH-2:0], pred_bit};
  assign win_errs_inc = win_errs + WE_W'(mismatch);

  // Next-state and next-value logic.
  // NOTE: every target gets a default first so no path leaves a value
  //       unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    seed_cnt_nxt  = seed_cnt;
    ok_cnt_nxt    = ok_cnt;
    win_bits_nxt  = win_bits;
    win_errs_nxt  = win_errs;
    bit_count_nxt = bit_count;
    err_count_nxt = err_count;
    rx_bit_nxt    = rx_bit;
    err_pulse_nxt = 1'b0;

    if (cke) begin
      rx_bit_nxt = slice_bit;
      unique case (state)
        ST_SEED: begin
          lfsr_nxt = seed_shift;
          if (seed_cnt == SEED_W'(LFSR_WIDTH - 1)) begin
            seed_cnt_nxt = '0;
            // An all-zero seed would keep the LFSR at zero, so collect a new one.
            if (seed_shift != '0) state_nxt = ST_VERIFY;
          end else begin
            seed_cnt_nxt = seed_cnt + 1'b1;
          end
        end

        ST_VERIFY: begin
          lfsr_nxt = pred_shift;
          if (mismatch) begin
            state_nxt    = ST_SEED;
            seed_cnt_nxt = '0;
            ok_cnt_nxt   = '0;
          end else if (ok_cnt == OK_W'(LOCK_COUNT - 1)) begin
            state_nxt    = ST_LOCKED;
            ok_cnt_nxt   = '0;
            win_bits_nxt = '0;
            win_errs_nxt = '0;
          end else begin
            ok_cnt_nxt = ok_cnt + 1'b1;
          end
        end

        ST_LOCKED: begin
          lfsr_nxt      = pred_shift;
          err_pulse_nxt = mismatch;
          if (bit_count != CNT_MAX) bit_count_nxt = bit_count + 1'b1;
          if (mismatch && (err_count != CNT_MAX)) err_count_nxt = err_count + 1'b1;

          if (win_errs_inc == WE_W'(LOSS_THRESH)) begin
            // Too many errors in this window: resynchronise. The result
            // counters are kept so the BER up to the loss is still readable.
            state_nxt    = ST_SEED;
            seed_cnt_nxt = '0;
            win_bits_nxt = '0;
            win_errs_nxt = '0;
          end else if (win_bits == WB_W'(LOSS_WINDOW - 1)) begin
            win_bits_nxt = '0;
            win_errs_nxt = '0;
          end else begin
            win_bits_nxt = win_bits + 1'b1;
            win_errs_nxt = win_errs_inc;
          end
        end

        default: state_nxt = ST_SEED;
      endcase
    end

    // The clear takes priority over an increment in the same cycle.
    if (clr_cnt) begin
      bit_count_nxt = '0;
      err_count_nxt = '0;
    end
  end

  // locked is a registered copy of "next state is LOCKED". It rises one clock
  // after the last qualifying bit and falls one clock after the loss.
  assign locked_nxt = (state_nxt == ST_LOCKED);

  // NOTE: sequential state uses non-blocking assignments only. All registers
  //       see the values from before the edge, so the order of these lines
  //       does not matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SEED;
      lfsr      <= '0;
      seed_cnt  <= '0;
      ok_cnt    <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      bit_count <= '0;
      err_count <= '0;
      rx_bit    <= 1'b0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      seed_cnt  <= seed_cnt_nxt;
      ok_cnt    <= ok_cnt_nxt;
      win_bits  <= win_bits_nxt;
      win_errs  <= win_errs_nxt;
      bit_count <= bit_count_nxt;
      err_count <= err_count_nxt;
      rx_bit    <= rx_bit_nxt;
      err_pulse <= err_pulse_nxt;
      locked    <= locked_nxt;
    end
  end

endmodule
